// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions: the commit-gather state encoding and the
// packet-id width helper, which the dispatch packetizer uses as well.
package VX_gpu_pkg;

  typedef enum logic [1:0] {
    GATHER_IDLE  = 2'd0,
    GATHER_ACCUM = 2'd1,
    GATHER_FULL  = 2'd2
  } gather_state_e;

  // Width of a packet index: max(1, clog2(threads/lanes)).
  function automatic int gather_pid_w(input int nt, input int nl);
    int np;
    np = nt / nl;
    return (np <= 2) ? 1 : $clog2(np);
  endfunction

endpackage

// File: rtl/vx_gather_accum.sv
// Commit-gather accumulator: NUM_THREADS tmask/data registers.
// Ports: clk/reset, wr_en_i, clr_i (start of gather), pid_i, tmask_i,
// data_i (one packet), tmask_o/data_o (merged record).
module vx_gather_accum #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 1,
  parameter int XLEN        = 32,
  parameter int PID_WIDTH   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en_i,
  input  logic                        clr_i,
  input  logic [PID_WIDTH-1:0]        pid_i,
  input  logic [NUM_LANES-1:0]        tmask_i,
  input  logic [NUM_LANES*XLEN-1:0]   data_i,
  output logic [NUM_THREADS-1:0]      tmask_o,
  output logic [NUM_THREADS*XLEN-1:0] data_o
);

  localparam int NP = NUM_THREADS / NUM_LANES;
  localparam int PW = NUM_LANES * XLEN;

  logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
  logic [NUM_THREADS*XLEN-1:0] data_q, data_d;

  // Clear happens before the packet write so a sop packet
  // lands in an otherwise zeroed record.
  always_comb begin
    tmask_d = clr_i ? '0 : tmask_q;
    data_d  = clr_i ? '0 : data_q;
    for (int p = 0; p < NP; p++) begin
      if (wr_en_i && (NP == 1 || pid_i == PID_WIDTH'(p))) begin
        tmask_d[p*NUM_LANES +: NUM_LANES] = tmask_i;
        data_d[p*PW +: PW]                = data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmask_q <= '0;
      data_q  <= '0;
    end else begin
      tmask_q <= tmask_d;
      data_q  <= data_d;
    end
  end

  assign tmask_o = tmask_q;
  assign data_o  = data_q;

endmodule

// File: rtl/vx_commit_gather.sv
// Reassembles pid/sop/eop tagged result packets into one commit record.
// Ports: in_* packet side (valid/ready), out_* record side (valid/ready),
// err sticky protocol error. Macro VX_GATHER_ERR_CHECK_EN enables err.
module vx_commit_gather
  import VX_gpu_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 1,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = 2,
  parameter int UUID_WIDTH  = 1,
  parameter int NR_BITS     = 5,
  parameter int PID_WIDTH   = gather_pid_w(NUM_THREADS, NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [XLEN-1:0]             in_pc,
  input  logic                        in_wb,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [XLEN-1:0]             out_pc,
  output logic                        out_wb,
  output logic [NR_BITS-1:0]          out_rd,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        err
);

  gather_state_e state_q, state_d;

  logic [UUID_WIDTH-1:0] uuid_q;
  logic [NW_WIDTH-1:0]   wid_q;
  logic [XLEN-1:0]       pc_q;
  logic                  wb_q;
  logic [NR_BITS-1:0]    rd_q;

  logic acc, fire, gathering, clr, wr_en;

  assign in_ready  = (state_q != GATHER_FULL) || out_ready;
  assign out_valid = (state_q == GATHER_FULL);
  assign fire      = out_valid && out_ready;
  assign acc       = in_valid && in_ready;
  assign gathering = (state_q == GATHER_ACCUM);
  assign clr       = acc && in_sop;
  // Non-sop packets outside a gather are dropped.
  assign wr_en     = acc && (in_sop || gathering);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GATHER_IDLE: begin
        if (clr) state_d = in_eop ? GATHER_FULL : GATHER_ACCUM;
      end
      GATHER_ACCUM: begin
        if (wr_en) state_d = in_eop ? GATHER_FULL : GATHER_ACCUM;
      end
      GATHER_FULL: begin
        if (fire) begin
          state_d = GATHER_IDLE;
          if (clr) state_d = in_eop ? GATHER_FULL : GATHER_ACCUM;
        end
      end
      default: state_d = GATHER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GATHER_IDLE;
      uuid_q  <= '0;
      wid_q   <= '0;
      pc_q    <= '0;
      wb_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        uuid_q <= in_uuid;
        wid_q  <= in_wid;
        pc_q   <= in_pc;
        wb_q   <= in_wb;
        rd_q   <= in_rd;
      end
    end
  end

  assign out_uuid = uuid_q;
  assign out_wid  = wid_q;
  assign out_pc   = pc_q;
  assign out_wb   = wb_q;
  assign out_rd   = rd_q;

  vx_gather_accum #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_LANES   (NUM_LANES),
    .XLEN        (XLEN),
    .PID_WIDTH   (PID_WIDTH)
  ) u_accum (
    .clk     (clk),
    .reset   (reset),
    .wr_en_i (wr_en),
    .clr_i   (clr),
    .pid_i   (in_pid),
    .tmask_i (in_tmask),
    .data_i  (in_data),
    .tmask_o (out_tmask),
    .data_o  (out_data)
  );

`ifdef VX_GATHER_ERR_CHECK_EN
  localparam int NP = NUM_THREADS / NUM_LANES;

  logic [NP-1:0] wm_q, wm_d, pid_oh;
  logic          err_q, err_hit;

  always_comb begin
    pid_oh  = '0;
    for (int p = 0; p < NP; p++) begin
      if (NP == 1 || in_pid == PID_WIDTH'(p)) pid_oh[p] = 1'b1;
    end
    wm_d    = wm_q;
    err_hit = 1'b0;
    if (acc) begin
      if (in_sop) begin
        wm_d    = pid_oh;
        err_hit = gathering;
      end else if (gathering) begin
        wm_d    = wm_q | pid_oh;
        err_hit = (|(wm_q & pid_oh)) ||
                  (in_wid != wid_q) ||
                  (in_uuid != uuid_q);
      end else begin
        err_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wm_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wm_q  <= wm_d;
      err_q <= err_q | err_hit;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vx_commit_gather.sv
// Self-checking bench for vx_commit_gather (8 threads, 2 lanes).
// Expected records are queued at stimulus time and popped on output fire.
module tb_vx_commit_gather;

  localparam int NT = 8;
  localparam int NL = 2;
  localparam int XL = 32;

`ifdef VX_GATHER_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [0:0]     in_uuid;
  logic [1:0]     in_wid;
  logic [1:0]     in_tmask;
  logic [31:0]    in_pc;
  logic           in_wb;
  logic [4:0]     in_rd;
  logic [63:0]    in_data;
  logic [1:0]     in_pid;
  logic           in_sop, in_eop;
  logic           out_valid, out_ready;
  logic [0:0]     out_uuid;
  logic [1:0]     out_wid;
  logic [7:0]     out_tmask;
  logic [31:0]    out_pc;
  logic           out_wb;
  logic [4:0]     out_rd;
  logic [255:0]   out_data;
  logic           err;

  vx_commit_gather #(
    .NUM_THREADS (NT),
    .NUM_LANES   (NL),
    .XLEN        (XL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_uuid   (in_uuid),
    .in_wid    (in_wid),
    .in_tmask  (in_tmask),
    .in_pc     (in_pc),
    .in_wb     (in_wb),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .in_pid    (in_pid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uuid  (out_uuid),
    .out_wid   (out_wid),
    .out_tmask (out_tmask),
    .out_pc    (out_pc),
    .out_wb    (out_wb),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   tmask;
    logic [255:0] data;
    logic [1:0]   wid;
    logic [0:0]   uuid;
    logic [31:0]  pc;
    logic         wb;
    logic [4:0]   rd;
  } rec_t;

  rec_t sb[$];
  int   fire_cyc[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic logic [255:0] place(input int pid,
                                         input logic [63:0] d);
    logic [255:0] r;
    r = '0;
    r[pid*64 +: 64] = d;
    return r;
  endfunction

  function automatic rec_t mk(input logic [7:0] tm, input logic [255:0] d,
                              input logic [1:0] wid, input logic [0:0] uuid,
                              input logic [31:0] pc, input logic wb,
                              input logic [4:0] rd);
    rec_t r;
    r.tmask = tm; r.data = d; r.wid = wid; r.uuid = uuid;
    r.pc = pc; r.wb = wb; r.rd = rd;
    return r;
  endfunction

  // Output monitor: compares every fired record with the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      rec_t e;
      fire_cyc.push_back(cyc);
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output tmask=%h", out_tmask);
      end else begin
        pass_cnt++;
        e = sb.pop_front();
        chk_cnt++;
        if (out_tmask !== e.tmask)
          $display("FAIL out_tmask got=%h exp=%h", out_tmask, e.tmask);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== e.data)
          $display("FAIL out_data got=%h exp=%h", out_data, e.data);
        else pass_cnt++;
        chk_cnt++;
        if ({out_wid, out_uuid, out_pc, out_wb, out_rd} !==
            {e.wid, e.uuid, e.pc, e.wb, e.rd})
          $display("FAIL out_header got=%h/%h/%h/%h/%h exp=%h/%h/%h/%h/%h",
                   out_wid, out_uuid, out_pc, out_wb, out_rd,
                   e.wid, e.uuid, e.pc, e.wb, e.rd);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Drives one packet starting just after a posedge and returns at
  // the posedge where it is accepted.
  task automatic send(input logic [1:0] pid, input logic sop,
                      input logic eop, input logic [1:0] tm,
                      input logic [63:0] d, input logic [1:0] wid,
                      input logic [0:0] uuid, input logic [31:0] pc,
                      input logic wb, input logic [4:0] rd);
    int n;
    #1;
    in_valid = 1'b1; in_pid = pid; in_sop = sop; in_eop = eop;
    in_tmask = tm; in_data = d; in_wid = wid; in_uuid = uuid;
    in_pc = pc; in_wb = wb; in_rd = rd;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL accept_timeout got=in_ready0 exp=in_ready1");
    end
    @(posedge clk);
  endtask

  task automatic release_in();
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_pid = '0; in_tmask = '0; in_data = '0; in_wid = '0;
    in_uuid = '0; in_pc = '0; in_wb = 1'b0; in_rd = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err);
    else pass_cnt++;
    chk_cnt++;
    if (out_tmask !== 8'h00) $display("FAIL rst_tmask got=%h exp=00", out_tmask);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 256'h0) $display("FAIL rst_data got=%h exp=0", out_data);
    else pass_cnt++;
    chk_cnt++;
    if ({out_wid, out_uuid, out_pc, out_wb, out_rd} !== 41'h0)
      $display("FAIL rst_header got=%h exp=0",
               {out_wid, out_uuid, out_pc, out_wb, out_rd});
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_full_gather();
    logic [255:0] exp_d;
    exp_d = '0;
    for (int k = 0; k < 8; k++) exp_d[k*32 +: 32] = 32'(k + 100);
    sb.push_back(mk(8'hFF, exp_d, 2'd1, 1'b1, 32'h100, 1'b1, 5'd5));
    @(posedge clk);
    for (int p = 0; p < 4; p++) begin
      if (p == 0)
        send(2'(p), 1'b1, 1'b0, 2'b11, {32'(2*p+101), 32'(2*p+100)},
             2'd1, 1'b1, 32'h100, 1'b1, 5'd5);
      else
        send(2'(p), 1'b0, p == 3, 2'b11, {32'(2*p+101), 32'(2*p+100)},
             2'd1, 1'b1, 32'hDEAD, 1'b0, 5'd31);
    end
    release_in();
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL full_latency got=%b exp=1", out_valid);
    else pass_cnt++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_sparse();
    sb.push_back(mk(8'b1000_0100,
                    place(1, 64'h0000_0B0B_0000_0A0A) |
                    place(3, 64'h0000_0D0D_0000_0C0C),
                    2'd2, 1'b0, 32'h200, 1'b0, 5'd7));
    @(posedge clk);
    send(2'd1, 1'b1, 1'b0, 2'b01, 64'h0000_0B0B_0000_0A0A,
         2'd2, 1'b0, 32'h200, 1'b0, 5'd7);
    send(2'd3, 1'b0, 1'b1, 2'b10, 64'h0000_0D0D_0000_0C0C,
         2'd2, 1'b0, 32'h0, 1'b1, 5'd0);
    release_in();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1 out_ready = 1'b0;
    sb.push_back(mk(8'h03, place(0, 64'h1111_2222_3333_4444),
                    2'd3, 1'b1, 32'h300, 1'b1, 5'd3));
    sb.push_back(mk(8'h08, place(1, 64'h5555_6666_7777_8888),
                    2'd0, 1'b0, 32'h400, 1'b1, 5'd4));
    send(2'd0, 1'b1, 1'b1, 2'b11, 64'h1111_2222_3333_4444,
         2'd3, 1'b1, 32'h300, 1'b1, 5'd3);
    #1;
    in_valid = 1'b1; in_pid = 2'd1; in_sop = 1'b1; in_eop = 1'b1;
    in_tmask = 2'b10; in_data = 64'h5555_6666_7777_8888;
    in_wid = 2'd0; in_uuid = 1'b0; in_pc = 32'h400; in_wb = 1'b1;
    in_rd = 5'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== 1'b1 || out_tmask !== 8'h03 ||
          out_data !== place(0, 64'h1111_2222_3333_4444) ||
          out_pc !== 32'h300)
        $display("FAIL bp_hold got=%b/%h/%h exp=1/03/%h",
                 out_valid, out_tmask, out_pc, 32'h300);
      else pass_cnt++;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    release_in();
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_tmask !== 8'h08)
      $display("FAIL bp_next got=%b/%h exp=1/08", out_valid, out_tmask);
    else pass_cnt++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [63:0] d;
    logic [1:0]  tm;
    n0 = fire_cyc.size();
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      d  = {32'(i * 7 + 1), 32'(i * 13 + 5)};
      tm = 2'(i % 4);
      sb.push_back(mk({6'b0, tm}, place(0, d), 2'(i), 1'(i),
                      32'(i * 4), 1'b1, 5'(i)));
      send(2'd0, 1'b1, 1'b1, tm, d, 2'(i), 1'(i), 32'(i * 4), 1'b1, 5'(i));
    end
    release_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (fire_cyc.size() - n0 != 10)
      $display("FAIL b2b_count got=%0d exp=10", fire_cyc.size() - n0);
    else pass_cnt++;
    chk_cnt++;
    if (fire_cyc.size() - n0 >= 10 && fire_cyc[n0+9] - fire_cyc[n0] == 9)
      pass_cnt++;
    else
      $display("FAIL b2b_span got=%0d exp=9",
               fire_cyc.size() > n0 ? fire_cyc[fire_cyc.size()-1] - fire_cyc[n0] : -1);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    send(2'd0, 1'b1, 1'b0, 2'b11, 64'hAAAA_AAAA_BBBB_BBBB,
         2'd1, 1'b0, 32'h500, 1'b1, 5'd9);
    send(2'd1, 1'b0, 1'b0, 2'b11, 64'hCCCC_CCCC_DDDD_DDDD,
         2'd1, 1'b0, 32'h500, 1'b1, 5'd9);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0 || out_tmask !== 8'h00)
      $display("FAIL midrst_clear got=%b/%h exp=0/00", out_valid, out_tmask);
    else pass_cnt++;
    sb.push_back(mk(8'hF0,
                    place(2, 64'h0000_0023_0000_0022) |
                    place(3, 64'h0000_0033_0000_0032),
                    2'd2, 1'b1, 32'h600, 1'b0, 5'd12));
    @(posedge clk);
    send(2'd2, 1'b1, 1'b0, 2'b11, 64'h0000_0023_0000_0022,
         2'd2, 1'b1, 32'h600, 1'b0, 5'd12);
    send(2'd3, 1'b0, 1'b1, 2'b11, 64'h0000_0033_0000_0032,
         2'd2, 1'b1, 32'h0, 1'b1, 5'd0);
    release_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL legal_traffic_err got=%b exp=0", err);
    else pass_cnt++;
  endtask

  task automatic test_err();
    @(posedge clk);
    send(2'd1, 1'b0, 1'b0, 2'b11, 64'h1234_5678_9ABC_DEF0,
         2'd0, 1'b0, 32'h700, 1'b1, 5'd1);
    release_in();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (err !== EXP_ERR) $display("FAIL err_sticky got=%b exp=%b", err, EXP_ERR);
      else pass_cnt++;
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL err_no_out got=%b exp=0", out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_full_gather();
    test_sparse();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_err();
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drain got=%0d exp=0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
